// File: rtl/and2_pipe_seq_pkg.sv
// Shared types and constants for the and2_pipe_seq sequencer.
//   state_t    : FSM state encoding (IDLE/EVAL/HOLD, 2'b11 unused)
//   CAP_IDX    : cap_en bit for the operand capture strobe
//   EVAL_IDX   : cap_en bit for the evaluate strobe
//   CNT_W_DEF  : default width of the completed-transaction counter
package and2_pipe_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVAL = 2'b01,
    HOLD = 2'b10
  } state_t;

  localparam int unsigned CAP_IDX   = 0;
  localparam int unsigned EVAL_IDX  = 1;
  localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/and2_pipe_seq_cnt.sv
// Saturating completed-transaction counter for and2_pipe_seq.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count one completed output handshake
//   cnt   : current count, sticks at all-ones
module and2_pipe_seq_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/and2_pipe_seq.sv
// Sequencer for a register -> AND -> register pipeline.
// Operands are captured on an in_valid/in_ready handshake, evaluated one
// cycle later, and the result is held on out_data until out_ready.
// Optional macro AND2_PIPE_SEQ_CNT_EN adds parameter CNT_W and output
// done_cnt, a saturating count of output handshakes.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   flush     : synchronous abort back to IDLE
//   in_valid  : operand pair valid
//   in_ready  : operands accepted this cycle
//   in_a/in_b : operands
//   out_valid : out_data valid (high exactly in HOLD)
//   out_ready : consumer accepts result
//   out_data  : registered a_q & b_q
//   cap_en    : [0] capture strobe, [1] evaluate strobe
//   busy      : state != IDLE
//   done_cnt  : completed handshakes (macro builds only)
module and2_pipe_seq
  import and2_pipe_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 1
`ifdef AND2_PIPE_SEQ_CNT_EN
  ,
  parameter int unsigned CNT_W = CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       cap_en,
  output logic             busy
`ifdef AND2_PIPE_SEQ_CNT_EN
  ,
  output logic [CNT_W-1:0] done_cnt
`endif
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] out_q;
  logic             accept;

  // rst_n gates in_ready so no capture strobe escapes while reset is held.
  assign in_ready  = rst_n & ~flush &
                     ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_q;

  always_comb begin
    cap_en           = '0;
    cap_en[CAP_IDX]  = accept;
    cap_en[EVAL_IDX] = (state_q == EVAL);
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) state_d = EVAL;
        EVAL: state_d = HOLD;
        // With flush low, out_ready & in_valid in HOLD is an accept.
        HOLD: if (out_ready) state_d = accept ? EVAL : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
    end else begin
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if ((state_q == EVAL) && !flush) begin
        out_q <= a_q & b_q;
      end
    end
  end

`ifdef AND2_PIPE_SEQ_CNT_EN
  and2_pipe_seq_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_valid & out_ready),
    .cnt  (done_cnt)
  );
`endif

endmodule

// File: tb/tb_and2_pipe_seq.sv
module tb_and2_pipe_seq;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   cap_en;
  logic         busy;
`ifdef AND2_PIPE_SEQ_CNT_EN
  localparam int unsigned CW = 2;
  logic [CW-1:0] done_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  and2_pipe_seq #(
    .WIDTH(W)
`ifdef AND2_PIPE_SEQ_CNT_EN
    ,
    .CNT_W(CW)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .cap_en   (cap_en),
    .busy     (busy)
`ifdef AND2_PIPE_SEQ_CNT_EN
    ,
    .done_cnt (done_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flush     = 1'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      #1;
      checks++;
      if ({out_valid, busy, cap_en, out_data} !== {1'b0, 1'b0, 2'b00, 4'b0000}) begin
        errors++;
        $display("FAIL reset_outputs: got %b expected %b",
                 {out_valid, busy, cap_en, out_data}, 8'b0);
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got in_ready/busy=%b expected 10", {in_ready, busy});
    end
    tick();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_a = 4'b1101; in_b = 4'b1011; out_ready = 1'b1;
    #1;
    checks++;
    if ({in_ready, cap_en, out_valid} !== {1'b1, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL single_accept: got %b expected 1010", {in_ready, cap_en, out_valid});
    end
    tick();
    in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom);
    #1;
    checks++;
    if ({busy, cap_en, out_valid} !== {1'b1, 2'b10, 1'b0}) begin
      errors++;
      $display("FAIL single_eval: got %b expected 1100", {busy, cap_en, out_valid});
    end
    tick();
    checks++;
    if ({out_valid, out_data, cap_en} !== {1'b1, 4'b1001, 2'b00}) begin
      errors++;
      $display("FAIL single_result: got %b expected 1100100", {out_valid, out_data, cap_en});
    end
    tick();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: got %b expected 00", {out_valid, busy});
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_a = 4'b0110; in_b = 4'b0111; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
      #1;
      checks++;
      if ({out_valid, out_data, in_ready, cap_en} !== {1'b1, 4'b0110, 1'b0, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %b expected 10110000", i,
                 {out_valid, out_data, in_ready, cap_en});
      end
      tick();
    end
    out_ready = 1'b1; in_valid = 1'b1; in_a = 4'b1111; in_b = 4'b0101;
    #1;
    checks++;
    if ({in_ready, cap_en, out_valid, out_data} !== {1'b1, 2'b01, 1'b1, 4'b0110}) begin
      errors++;
      $display("FAIL bp_release: got %b expected 10110110",
               {in_ready, cap_en, out_valid, out_data});
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, cap_en} !== {1'b0, 2'b10}) begin
      errors++;
      $display("FAIL bp_eval2: got %b expected 010", {out_valid, cap_en});
    end
    tick();
    checks++;
    if ({out_valid, out_data} !== {1'b1, 4'b0101}) begin
      errors++;
      $display("FAIL bp_result2: got %b expected 10101", {out_valid, out_data});
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_streaming();
    logic [W-1:0] va[8];
    logic [W-1:0] vb[8];
    logic [W-1:0] q[$];
    logic [W-1:0] exp_d;
    int sent = 0;
    int got  = 0;
    logic exp_rdy, exp_ov;
    for (int i = 0; i < 8; i++) begin
      va[i] = W'($urandom);
      vb[i] = W'($urandom);
    end
    out_ready = 1'b1;
    // Accepts land on even cycles 0..14, results on even cycles 2..16.
    for (int k = 0; k <= 16; k++) begin
      in_valid = (sent < 8);
      in_a = va[sent % 8];
      in_b = vb[sent % 8];
      #1;
      exp_rdy = (k % 2 == 0);
      exp_ov  = (k >= 2) && (k % 2 == 0);
      checks++;
      if ({in_ready, out_valid} !== {exp_rdy, exp_ov}) begin
        errors++;
        $display("FAIL stream_hs[%0d]: got rdy/ov=%b expected %b", k,
                 {in_ready, out_valid}, {exp_rdy, exp_ov});
      end
      if (out_valid === 1'b1) begin
        exp_d = (q.size() > 0) ? q.pop_front() : 'x;
        got++;
        checks++;
        if (out_data !== exp_d) begin
          errors++;
          $display("FAIL stream_data[%0d]: got %h expected %h", got - 1, out_data, exp_d);
        end
      end
      if (in_valid && exp_rdy) begin
        q.push_back(in_a & in_b);
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid, 8'(got)} !== {1'b0, 1'b0, 8'd8}) begin
      errors++;
      $display("FAIL stream_done: got busy/ov/count=%b/%b/%0d expected 0/0/8",
               busy, out_valid, got);
    end
    tick();
  endtask

  task automatic test_flush();
    // Flush while evaluating.
    out_ready = 1'b1; in_valid = 1'b1; in_a = 4'b1111; in_b = 4'b1111;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL flush_eval_rdy: got %b expected 10", {busy, in_ready});
    end
    tick();
    flush = 1'b0;
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL flush_eval_idle: got %b expected 00", {busy, out_valid});
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_eval_noout: got %b expected 0", out_valid);
    end
    // Flush coincident with in_valid in IDLE.
    flush = 1'b1; in_valid = 1'b1; in_a = 4'b0000; in_b = 4'b0000;
    #1;
    checks++;
    if ({in_ready, cap_en} !== 3'b000) begin
      errors++;
      $display("FAIL flush_idle_noacc: got %b expected 000", {in_ready, cap_en});
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_busy: got %b expected 0", busy);
    end
    // Flush while holding a result.
    out_ready = 1'b0; in_valid = 1'b1; in_a = 4'b1010; in_b = 4'b1110;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, in_ready} !== {1'b1, 4'b1010, 1'b0}) begin
      errors++;
      $display("FAIL flush_hold_pre: got %b expected 110100", {out_valid, out_data, in_ready});
    end
    tick();
    flush = 1'b0;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL flush_hold_drop: got %b expected 00", {out_valid, busy});
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] exp_d;
    int  age = -1;  // cycles since the in-flight pair was accepted, -1 if none
    logic exp_ov, exp_rdy, acc;
    flush = 1'b0;
    for (int k = 0; k < 300; k++) begin
      in_valid  = (k < 290) ? 1'($urandom) : 1'b0;
      out_ready = (k < 290) ? ($urandom_range(3) != 0) : 1'b1;
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      #1;
      exp_ov  = (age >= 2);
      exp_rdy = (age < 0) || ((age >= 2) && out_ready);
      acc     = in_valid & exp_rdy;
      checks++;
      if ({out_valid, in_ready, cap_en} !== {exp_ov, exp_rdy, (age == 1), acc}) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got ov/rdy/cap=%b expected %b", k,
                 {out_valid, in_ready, cap_en}, {exp_ov, exp_rdy, (age == 1), acc});
      end
      if (exp_ov) begin
        exp_d = (q.size() > 0) ? q[0] : 'x;
        checks++;
        if (out_data !== exp_d) begin
          errors++;
          $display("FAIL rand_data[%0d]: got %h expected %h", k, out_data, exp_d);
        end
        if (out_ready && q.size() > 0) void'(q.pop_front());
      end
      if (acc) begin
        q.push_back(in_a & in_b);
        age = 1;
      end else if ((age >= 2) && out_ready) begin
        age = -1;
      end else if (age >= 0) begin
        age = (age < 2) ? age + 1 : 2;
      end
      tick();
    end
    checks++;
    if ({busy, 8'(q.size())} !== {1'b0, 8'd0}) begin
      errors++;
      $display("FAIL rand_drain: got busy/pending=%b/%0d expected 0/0", busy, q.size());
    end
  endtask

  task automatic test_counter();
`ifdef AND2_PIPE_SEQ_CNT_EN
    logic [CW-1:0] exp_c;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (done_cnt !== 2'd0) begin
      errors++;
      $display("FAIL cnt_reset: got %0d expected 0", done_cnt);
    end
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      exp_c = (i > 3) ? 2'd3 : CW'(i);
      checks++;
      if (done_cnt !== exp_c) begin
        errors++;
        $display("FAIL cnt_step[%0d]: got %0d expected %0d", i, done_cnt, exp_c);
      end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (done_cnt !== 2'd3) begin
      errors++;
      $display("FAIL cnt_flush: got %0d expected 3", done_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (done_cnt !== 2'd0) begin
      errors++;
      $display("FAIL cnt_rst: got %0d expected 0", done_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
`endif
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_flush();
    test_random();
    test_counter();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
